// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int unsigned KP_ROWS = 4;
  localparam int unsigned KP_COLS = 4;

  typedef enum logic [1:0] {
    StScan      = 2'd0,
    StPressDb   = 2'd1,
    StHeld      = 2'd2,
    StReleaseDb = 2'd3
  } kp_state_e;

  // Index of the lowest-numbered low (active) row; 0 when none is low.
  function automatic logic [1:0] prio_row(input logic [KP_ROWS-1:0] rs);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = KP_ROWS - 1; i >= 0; i--) begin
      if (!rs[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs.
module sync_2ff #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: column drive, per-key debounce, valid/ack key handoff.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 12000,
  parameter int unsigned DB_TICKS = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KP_ROWS-1:0] row_n,
  output logic [KP_COLS-1:0] col_n,
  output logic [3:0]         key_code,
  output logic               key_valid,
  input  logic               key_ack,
  output logic               key_down,
  output logic               overrun
);

  localparam int unsigned    DivW     = $clog2(SCAN_DIV);
  localparam int unsigned    DcW      = $clog2(DB_TICKS + 1);
  localparam logic [DivW-1:0] DivMax  = DivW'(SCAN_DIV - 1);
  localparam logic [DcW-1:0]  DcOne   = DcW'(1);
  localparam logic [DcW-1:0]  DcTarget = DcW'(DB_TICKS);

  logic [KP_ROWS-1:0] rs;
  logic [DivW-1:0]    div_q, div_d;
  logic               tick;
  logic [1:0]         ci_q, ci_d;
  logic [KP_COLS-1:0] col_q, col_d;
  kp_state_e          state_q, state_d;
  logic [1:0]         r_q, r_d;
  logic [1:0]         c_q, c_d;
  logic [DcW-1:0]     dc_q, dc_d;
  logic               hit, row_low;
  logic               cap;
  logic [3:0]         cap_code;
  logic               down_q, down_d;
  logic [3:0]         code_q, code_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;

  sync_2ff #(
    .WIDTH     (KP_ROWS),
    .RESET_VAL ({KP_ROWS{1'b1}})
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_n),
    .q   (rs)
  );

  // Scan-tick divider: one tick every SCAN_DIV cycles.
  always_comb begin
    tick  = (div_q == DivMax);
    div_d = tick ? '0 : div_q + DivW'(1);
  end

  // Scan/debounce FSM; every transition is gated by tick.
  always_comb begin
    state_d = state_q;
    ci_d    = ci_q;
    r_d     = r_q;
    c_d     = c_q;
    dc_d    = dc_q;
    cap     = 1'b0;
    hit     = ~&rs;
    row_low = ~rs[r_q];
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (hit) begin
            r_d  = prio_row(rs);
            c_d  = ci_q;
            dc_d = DcOne;
            if (DcOne == DcTarget) begin
              cap     = 1'b1;
              state_d = StHeld;
            end else begin
              state_d = StPressDb;
            end
          end else begin
            ci_d = ci_q + 2'd1;
          end
        end
        StPressDb: begin
          if (row_low) begin
            dc_d = dc_q + DcOne;
            if (dc_q + DcOne == DcTarget) begin
              cap     = 1'b1;
              state_d = StHeld;
            end
          end else begin
            state_d = StScan;
            ci_d    = c_q + 2'd1;
          end
        end
        StHeld: begin
          if (!row_low) begin
            dc_d = DcOne;
            if (DcOne == DcTarget) begin
              state_d = StScan;
              ci_d    = c_q + 2'd1;
            end else begin
              state_d = StReleaseDb;
            end
          end
        end
        StReleaseDb: begin
          if (row_low) begin
            state_d = StHeld;
          end else if (dc_q + DcOne == DcTarget) begin
            state_d = StScan;
            ci_d    = c_q + 2'd1;
          end else begin
            dc_d = dc_q + DcOne;
          end
        end
        default: state_d = StScan;
      endcase
    end
    // r_d/c_d equal r_q/c_q in PRESS_DB, and hold the fresh hit in SCAN.
    cap_code = {r_d, c_d};
    col_d    = '1;
    col_d[ci_d] = 1'b0;
    down_d   = (state_d == StHeld) || (state_d == StReleaseDb);
  end

  // Key handoff: load on capture when free or being consumed, else flag overrun.
  always_comb begin
    code_d    = code_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (cap) begin
      if (!valid_q || key_ack) begin
        code_d  = cap_code;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      ci_q      <= 2'd0;
      col_q     <= 4'b1110;
      state_q   <= StScan;
      r_q       <= 2'd0;
      c_q       <= 2'd0;
      dc_q      <= '0;
      down_q    <= 1'b0;
      code_q    <= 4'h0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      ci_q      <= ci_d;
      col_q     <= col_d;
      state_q   <= state_d;
      r_q       <= r_d;
      c_q       <= c_d;
      dc_q      <= dc_d;
      down_q    <= down_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign col_n     = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 active-low matrix keypad on the StepFPGA board and produces debounced hex key codes 0x0–0xF through a valid/ack handshake. It is the input-side counterpart of the two-digit seven-segment driver: the driver turns a hex nibble into lit segments, and this block turns a pressed key back into a hex nibble. Its `key_code` feeds the seven-segment data path or a PicoRV peripheral register directly.

## Interface
- `SCAN_DIV`, 12000: clock cycles per scan tick (1 ms at 12 MHz); ≥ 2.
- `DB_TICKS`, 20: consecutive matching ticks required for press and for release; ≥ 1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `row_n`  in  4  keypad rows, pulled up, low = contact; asynchronous to `clk`.
- `col_n`  out  4  column drive, exactly one bit low at all times.
- `key_code`  out  4  captured key, `row*4 + col`.
- `key_valid`  out  1  `key_code` holds an unconsumed key.
- `key_ack`  in  1  consumer takes the key; sampled on any cycle.
- `key_down`  out  1  a debounced key is currently held.
- `overrun`  out  1  sticky; a key was lost because `key_valid` was still set.

## Operation
- **Row synchronisation:** `row_n` passes through a 2-FF synchroniser. All decisions use the synchronised value `rs`.
- **Scan tick:** a divider counts 0..`SCAN_DIV`-1; `tick` is high for one cycle at `SCAN_DIV`-1. Column index `ci` (2 bits) changes only on a tick, so each column settles for `SCAN_DIV` cycles before it is sampled. `col_n = ~(1 << ci)`.
- **Row priority:** lowest row index wins; `hit` = any `rs` bit low.
- **FSM states:** SCAN, PRESS_DB, HELD, RELEASE_DB. All transitions occur only on `tick` cycles.
- **SCAN**
  - `hit` → latch `r` (priority row) and `c = ci`, debounce counter `dc = 1`, go to PRESS_DB. `ci` is frozen.
  - No `hit` → `ci = ci + 1`, wrapping 3→0.
- **PRESS_DB**
  - Same row `r` still low → `dc++`.
  - Otherwise → SCAN with `ci = c + 1`.
  - When `dc` reaches `DB_TICKS`: capture `r*4 + c`, go to HELD.
  - `DB_TICKS = 1` captures on the first matching tick.
- **HELD:** `key_down = 1`. Row `r` high → `dc = 1`, go to RELEASE_DB.
- **RELEASE_DB**
  - Row `r` low again → back to HELD.
  - Row `r` high for `DB_TICKS` consecutive ticks → SCAN with `ci = c + 1`, `key_down = 0`.
- **Other keys:** presses on other rows or columns are ignored while not in SCAN.
- **Capture event handling:**
  - `key_valid = 0`, or `key_ack = 1` in the same cycle → load `key_code`, set `key_valid = 1`.
  - Otherwise → `key_code` unchanged, `overrun = 1`.
- **Acknowledge:** `key_ack` with `key_valid = 1` and no capture clears `key_valid` and `overrun`. `key_ack` while `key_valid = 0` has no effect.

## Timing
- **Reset values** (asynchronous, apply immediately): state SCAN, `ci = 0`, `col_n = 4'b1110`, divider 0, `dc = 0`, `key_code = 0`, `key_valid = 0`, `key_down = 0`, `overrun = 0`, synchroniser flops = 4'b1111.
- **Reset mid-debounce or mid-hold:** all progress is discarded. After release, scanning restarts at column 0 with no spurious `key_valid`.
- **Press latency:**
  - Synchroniser: 2 cycles.
  - Then the first tick on the key's column.
  - Then `DB_TICKS`-1 further ticks.
  - `key_valid` and `key_down` rise one cycle after the final tick edge, i.e. registered on that tick.
- **Release:** `key_down` falls on the `DB_TICKS`-th consecutive high tick after release.
- **Handshake:** `key_valid` stays high until acknowledged; `key_code` is stable while `key_valid = 1`.
- **Outputs:** all outputs are registered, with no combinational path from `row_n` or `key_ack` to any output.

## Structure
- Shared package/header `keypad_pkg`: state encodings (SCAN=0, PRESS_DB=1, HELD=2, RELEASE_DB=3), `KP_ROWS = 4`, `KP_COLS = 4`.
- Sub-module `sync_2ff` (parameterised width), reusable for other board inputs. Divider, FSM and handshake stay in `keypad_scan`.

## Test plan
- **Single press:** `SCAN_DIV = 4`, `DB_TICKS = 3`; hold row 2 low only while col 1 is driven, steady → `key_code = 0x9`, `key_valid` after 3 ticks on col 1, `key_down = 1`; ack → `key_valid = 0`; release → `key_down` falls after 3 high ticks, scan resumes at col 2.
- **Bounce:** row 0 / col 3 low for 1 tick, high for 1, then steady low → no capture until 3 consecutive lows; final `key_code = 0x3`; exactly one `key_valid`.
- **Overrun:** capture 0x5 with no ack, release, press 0xA → `key_code` stays 0x5, `overrun = 1`; ack → both cleared.
- **Ack coincident with capture:** `key_ack` in the capture cycle of a second key 0xF → `key_valid` stays 1, `key_code = 0xF`, `overrun = 0`.
- **Async reset in HELD:** assert `rst` mid-cycle → outputs immediately at reset values, `col_n = 1110`; key still held after release → recaptured normally.
- **Column wrap:** no keys pressed for 10 ticks → `col_n` cycles 1110, 1101, 1011, 0111, 1110 …, exactly one low bit each cycle.
